// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared read-mode encodings for the 2R1W register file
package regfile_pkg;

  // Read/write collision policy selected by the RD_MODE parameter
  localparam int RD_FIRST = 0;  // same-address read returns pre-write contents
  localparam int WR_FIRST = 1;  // same-address read returns strobed write data merged in

endpackage

// File: rtl/regfile_rd_port.sv
// rtl/regfile_rd_port.sv - one registered read port: range check, write bypass, output register
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 8,
  parameter int ADDR_W  = 4,
  parameter int RD_MODE = RD_FIRST
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [WIDTH-1:0]  mem_word,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [WIDTH/8-1:0] wr_strb,
  output logic [WIDTH-1:0]  rd_data,
  output logic              rd_valid,
  output logic              addr_err
);

  localparam int NB = WIDTH / 8;

  logic             in_range;
  logic             hit;
  logic [WIDTH-1:0] next_word;

  // Replace only the strobed byte lanes of the stored word with the write data
  function automatic logic [WIDTH-1:0] merge_bytes(input logic [WIDTH-1:0] old_word,
                                                   input logic [WIDTH-1:0] new_word,
                                                   input logic [NB-1:0]    strb);
    logic [WIDTH-1:0] res;
    res = old_word;
    for (int b = 0; b < NB; b++) begin
      if (strb[b]) res[8*b +: 8] = new_word[8*b +: 8];
    end
    return res;
  endfunction

  assign in_range = 32'(rd_addr) < 32'(DEPTH);
  assign addr_err = rd_en & ~in_range;
  assign hit      = wr_en && (wr_addr == rd_addr) && in_range;

  // Select the word to capture: zero when out of range, bypassed write data in write-first mode
  always_comb begin
    next_word = mem_word;
    if ((RD_MODE == WR_FIRST) && hit) next_word = merge_bytes(mem_word, wr_data, wr_strb);
    if (!in_range) next_word = '0;
  end

  // Output register: valid pulses one cycle after a request, data holds otherwise
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= next_word;
    end
  end

endmodule

// File: rtl/regfile_param_2r1w.sv
// rtl/regfile_param_2r1w.sv - parameterised flip-flop register file, two read ports and one byte-strobed write port
module regfile_param_2r1w
  import regfile_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 8,
  parameter int ADDR_W  = 4,
  parameter int RD_MODE = RD_FIRST
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               WrEn,
  input  logic [ADDR_W-1:0]  WrAddr,
  input  logic [WIDTH-1:0]   WrData,
  input  logic [WIDTH/8-1:0] WrStrb,
  input  logic               RdEnA,
  input  logic [ADDR_W-1:0]  RdAddrA,
  output logic [WIDTH-1:0]   RdDataA,
  output logic               RdValidA,
  input  logic               RdEnB,
  input  logic [ADDR_W-1:0]  RdAddrB,
  output logic [WIDTH-1:0]   RdDataB,
  output logic               RdValidB,
  output logic               AddrErr
);

  localparam int NB = WIDTH / 8;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] word_a;
  logic [WIDTH-1:0] word_b;
  logic             wr_in_range;
  logic             err_a;
  logic             err_b;

  assign wr_in_range = 32'(WrAddr) < 32'(DEPTH);

  // Storage update: only strobed bytes of an in-range address change; reset clears everything
  always_ff @(posedge CLK) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (WrEn) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (WrAddr == ADDR_W'(i)) begin
          for (int b = 0; b < NB; b++) begin
            if (WrStrb[b]) mem[i][8*b +: 8] <= WrData[8*b +: 8];
          end
        end
      end
    end
  end

  // Read muxes decode addresses explicitly so out-of-range addresses never index the array
  always_comb begin
    word_a = '0;
    word_b = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (RdAddrA == ADDR_W'(i)) word_a = mem[i];
      if (RdAddrB == ADDR_W'(i)) word_b = mem[i];
    end
  end

  regfile_rd_port #(
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .ADDR_W  (ADDR_W),
    .RD_MODE (RD_MODE)
  ) u_port_a (
    .clk      (CLK),
    .rst      (RST),
    .rd_en    (RdEnA),
    .rd_addr  (RdAddrA),
    .mem_word (word_a),
    .wr_en    (WrEn),
    .wr_addr  (WrAddr),
    .wr_data  (WrData),
    .wr_strb  (WrStrb),
    .rd_data  (RdDataA),
    .rd_valid (RdValidA),
    .addr_err (err_a)
  );

  regfile_rd_port #(
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .ADDR_W  (ADDR_W),
    .RD_MODE (RD_MODE)
  ) u_port_b (
    .clk      (CLK),
    .rst      (RST),
    .rd_en    (RdEnB),
    .rd_addr  (RdAddrB),
    .mem_word (word_b),
    .wr_en    (WrEn),
    .wr_addr  (WrAddr),
    .wr_data  (WrData),
    .wr_strb  (WrStrb),
    .rd_data  (RdDataB),
    .rd_valid (RdValidB),
    .addr_err (err_b)
  );

  // Registered error flag: high for one cycle after any out-of-range access
  always_ff @(posedge CLK) begin
    if (!RST) AddrErr <= 1'b0;
    else      AddrErr <= (WrEn & ~wr_in_range) | err_a | err_b;
  end

endmodule
